imm_pack: RTL and testbench

Pipelined RISC-V instruction encoder. It is the inverse of the pipeline's immediate extractor: it accepts decoded fields plus a 32-bit immediate and a format type, and packs them into a 32-bit instruction word. It also flags immediates that the chosen format cannot represent. It sits in front of the debug program-buffer writer and the self-test instruction generator, and uses a valid/ready handshake on both sides.

---
 rtl/imm_pack_pkg.sv | 32 +++
 rtl/imm_pack_range_check.sv | 38 +++
 rtl/imm_pack.sv | 139 +++++++++++++
 tb/tb_imm_pack.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pack_pkg.sv
// imm_pack_pkg
//   Shared definitions for the RV32I instruction encoder: the instruction
//   format codes carried on TYPE, the canonical NOP word, and the struct
//   used to carry one decoded beat through the pipeline.
package imm_pack_pkg;

    typedef enum logic [2:0] {
        T_ITYPE = 3'd0,
        T_STYPE = 3'd1,
        T_BTYPE = 3'd2,
        T_UTYPE = 3'd3,
        T_JTYPE = 3'd4,
        T_NTYPE = 3'd5,
        T_RTYPE = 3'd6,
        T_RSVD  = 3'd7
    } fmt_e;

    // addi x0,x0,0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        fmt_e        fmt;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
    } fields_t;

endpackage

// File: rtl/imm_pack_range_check.sv
// imm_range_check
//   Combinational check of whether an immediate fits the chosen format.
//   Ports:
//     fmt_i       instruction format
//     imm_i       sign-extended byte offset, or upper immediate for utype
//     range_err_o high when imm_i cannot be encoded exactly in fmt_i
module imm_range_check
    import imm_pack_pkg::*;
(
    input  fmt_e        fmt_i,
    input  logic [31:0] imm_i,
    output logic        range_err_o
);

    // A field of N signed bits holds imm exactly when every bit from the
    // field's sign bit upward is a copy of that sign bit.
    logic sext12_ok;
    logic sext13_ok;
    logic sext21_ok;

    always_comb begin
        sext12_ok = (imm_i[31:11] == '0) || (imm_i[31:11] == '1);
        sext13_ok = (imm_i[31:12] == '0) || (imm_i[31:12] == '1);
        sext21_ok = (imm_i[31:20] == '0) || (imm_i[31:20] == '1);

        range_err_o = 1'b0;
        case (fmt_i)
            T_ITYPE, T_STYPE: range_err_o = !sext12_ok;
            // Branch and jump offsets are halfword aligned; bit 0 is not encoded.
            T_BTYPE:          range_err_o = !sext13_ok || imm_i[0];
            T_JTYPE:          range_err_o = !sext21_ok || imm_i[0];
            T_UTYPE:          range_err_o = (imm_i[11:0] != '0);
            T_NTYPE, T_RTYPE: range_err_o = 1'b0;
            default:          range_err_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_pack.sv
// imm_pack
//   Two-stage RV32I instruction encoder with valid/ready on both sides.
//   Stage 1 registers the decoded fields and the immediate range flag;
//   stage 2 packs the instruction word and holds it for the consumer.
//   Ports:
//     CLK, RST             clock, asynchronous active-high reset
//     IN_VALID / IN_READY  input handshake
//     TYPE, OPCODE, RD, RS1, RS2, FUNCT3, FUNCT7, IMM   decoded beat
//     OUT_VALID / OUT_READY output handshake
//     INSTR                encoded word
//     RANGE_ERR            IMM was not representable (word still packed)
//     ENC_COUNT            words delivered, saturating at 16'hFFFF
module imm_pack
    import imm_pack_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [2:0]  TYPE,
    input  logic [6:0]  OPCODE,
    input  logic [4:0]  RD,
    input  logic [4:0]  RS1,
    input  logic [4:0]  RS2,
    input  logic [2:0]  FUNCT3,
    input  logic [6:0]  FUNCT7,
    input  logic [31:0] IMM,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [31:0] INSTR,
    output logic        RANGE_ERR,
    output logic [15:0] ENC_COUNT
);

    function automatic logic [31:0] pack_word(input fields_t f);
        logic [31:0] w;
        case (f.fmt)
            T_ITYPE: w = {f.imm[11:0], f.rs1, f.funct3, f.rd, f.opcode};
            T_STYPE: w = {f.imm[11:5], f.rs2, f.rs1, f.funct3, f.imm[4:0], f.opcode};
            T_BTYPE: w = {f.imm[12], f.imm[10:5], f.rs2, f.rs1, f.funct3,
                          f.imm[4:1], f.imm[11], f.opcode};
            T_UTYPE: w = {f.imm[31:12], f.rd, f.opcode};
            T_JTYPE: w = {f.imm[20], f.imm[10:1], f.imm[11], f.imm[19:12], f.rd, f.opcode};
            T_RTYPE: w = {f.funct7, f.rs2, f.rs1, f.funct3, f.rd, f.opcode};
            T_NTYPE: w = {25'd0, f.opcode};
            default: w = NOP_INSTR;
        endcase
        return w;
    endfunction

    fields_t     fld_in;
    logic        rerr_in;

    fields_t     fld_p1_q,   fld_p1_d;
    logic        rerr_p1_q,  rerr_p1_d;
    logic        vld_p1_q,   vld_p1_d;

    logic [31:0] instr_p2_q, instr_p2_d;
    logic        rerr_p2_q,  rerr_p2_d;
    logic        vld_p2_q,   vld_p2_d;

    logic [15:0] cnt_q,      cnt_d;

    logic        adv_p2;
    logic        rdy_p1;
    logic        accept;

    always_comb begin
        fld_in.fmt    = fmt_e'(TYPE);
        fld_in.opcode = OPCODE;
        fld_in.rd     = RD;
        fld_in.rs1    = RS1;
        fld_in.rs2    = RS2;
        fld_in.funct3 = FUNCT3;
        fld_in.funct7 = FUNCT7;
        fld_in.imm    = IMM;
    end

    imm_range_check u_range_check (
        .fmt_i       (fld_in.fmt),
        .imm_i       (IMM),
        .range_err_o (rerr_in)
    );

    always_comb begin
        adv_p2 = OUT_READY || !vld_p2_q;
        rdy_p1 = !vld_p1_q || adv_p2;
        accept = IN_VALID && rdy_p1;

        // ---- stage 1: capture fields and range flag
        vld_p1_d  = rdy_p1 ? IN_VALID : vld_p1_q;
        fld_p1_d  = accept ? fld_in   : fld_p1_q;
        rerr_p1_d = accept ? rerr_in  : rerr_p1_q;

        // ---- stage 2: pack; the word only changes when a new beat moves in,
        // so it holds steady for as long as the consumer stalls.
        vld_p2_d   = adv_p2 ? vld_p1_q : vld_p2_q;
        instr_p2_d = instr_p2_q;
        rerr_p2_d  = rerr_p2_q;
        if (adv_p2 && vld_p1_q) begin
            instr_p2_d = pack_word(fld_p1_q);
            rerr_p2_d  = rerr_p1_q;
        end

        cnt_d = cnt_q;
        if (vld_p2_q && OUT_READY && (cnt_q != 16'hFFFF))
            cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            vld_p1_q   <= 1'b0;
            vld_p2_q   <= 1'b0;
            instr_p2_q <= '0;
            rerr_p2_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            vld_p1_q   <= vld_p1_d;
            vld_p2_q   <= vld_p2_d;
            instr_p2_q <= instr_p2_d;
            rerr_p2_q  <= rerr_p2_d;
            cnt_q      <= cnt_d;
        end
    end

    // Stage 1 payload is qualified by vld_p1_q and needs no reset.
    always_ff @(posedge CLK) begin
        fld_p1_q  <= fld_p1_d;
        rerr_p1_q <= rerr_p1_d;
    end

    // Held low for the whole reset interval, not just until the flops clear.
    assign IN_READY  = rdy_p1 && !RST;
    assign OUT_VALID = vld_p2_q;
    assign INSTR     = instr_p2_q;
    assign RANGE_ERR = rerr_p2_q;
    assign ENC_COUNT = cnt_q;

endmodule

// File: tb/tb_imm_pack.sv
module tb_imm_pack;

    logic        CLK = 1'b0;
    logic        RST;
    logic        IN_VALID;
    logic        IN_READY;
    logic [2:0]  TYPE;
    logic [6:0]  OPCODE;
    logic [4:0]  RD;
    logic [4:0]  RS1;
    logic [4:0]  RS2;
    logic [2:0]  FUNCT3;
    logic [6:0]  FUNCT7;
    logic [31:0] IMM;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [31:0] INSTR;
    logic        RANGE_ERR;
    logic [15:0] ENC_COUNT;

    int n_assert = 0;
    int n_fail   = 0;

    imm_pack dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .TYPE      (TYPE),
        .OPCODE    (OPCODE),
        .RD        (RD),
        .RS1       (RS1),
        .RS2       (RS2),
        .FUNCT3    (FUNCT3),
        .FUNCT7    (FUNCT7),
        .IMM       (IMM),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .INSTR     (INSTR),
        .RANGE_ERR (RANGE_ERR),
        .ENC_COUNT (ENC_COUNT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_beat(input logic [2:0] t, input logic [6:0] op, input logic [4:0] rd,
                            input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm);
        TYPE = t; OPCODE = op; RD = rd; RS1 = rs1; RS2 = rs2;
        FUNCT3 = f3; FUNCT7 = f7; IMM = imm;
    endtask

    // Called 1 time unit after a rising edge: presents the beat for one cycle,
    // then returns 1 time unit after the second following edge, when the
    // encoded word should be on the output.
    task automatic run_one();
        IN_VALID = 1'b1;
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        @(posedge CLK); #1;
    endtask

    task automatic pulse_reset();
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
    endtask

    function automatic logic [31:0] ext_imm(input logic [2:0] t, input logic [31:0] i);
        logic [31:0] r;
        case (t)
            3'd0:    r = {{20{i[31]}}, i[31:20]};
            3'd1:    r = {{20{i[31]}}, i[31:25], i[11:7]};
            3'd2:    r = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            3'd3:    r = {i[31:12], 12'b0};
            default: r = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
        endcase
        return r;
    endfunction

    logic [31:0] exp_bp [5];
    logic [31:0] hold;
    logic        have_hold;
    logic        saw_stall;
    int          sent;
    int          rcv;
    logic [31:0] r;
    logic [31:0] rimm;
    logic [4:0]  rrd, rrs1, rrs2;
    logic [2:0]  rf3;
    logic [6:0]  rop;

    initial begin
        RST = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b1;
        set_beat(3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);

        // Reset state
        #12;
        chk("rst_in_ready",  IN_READY,  1'b0);
        chk("rst_out_valid", OUT_VALID, 1'b0);
        chk("rst_instr",     INSTR,     32'h0);
        chk("rst_range_err", RANGE_ERR, 1'b0);
        chk("rst_enc_count", ENC_COUNT, 16'h0);
        @(posedge CLK); #1;
        RST = 1'b0;
        @(posedge CLK); #1;
        chk("post_rst_in_ready", IN_READY, 1'b1);

        // addi x1,x0,-1
        set_beat(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
        run_one();
        chk("addi_valid", OUT_VALID, 1'b1);
        chk("addi_instr", INSTR, 32'hFFF0_0093);
        chk("addi_rerr",  RANGE_ERR, 1'b0);

        // jal x0,+8
        set_beat(3'd4, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);
        run_one();
        chk("jal_instr", INSTR, 32'h0080_006F);
        chk("jal_rerr",  RANGE_ERR, 1'b0);

        // beq x0,x0,-4
        set_beat(3'd2, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC);
        run_one();
        chk("beq_instr", INSTR, 32'hFE00_0EE3);
        chk("beq_rerr",  RANGE_ERR, 1'b0);

        // sw x2,-8(x1)
        set_beat(3'd1, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'hFFFF_FFF8);
        run_one();
        chk("sw_instr", INSTR, 32'hFE20_AC23);
        chk("sw_rerr",  RANGE_ERR, 1'b0);

        // add x3,x1,x2
        set_beat(3'd6, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'hDEAD_BEEF);
        run_one();
        chk("add_instr", INSTR, 32'h0020_81B3);
        chk("add_rerr",  RANGE_ERR, 1'b0);

        // ntype keeps only the opcode
        set_beat(3'd5, 7'h0F, 5'd7, 5'd9, 5'd11, 3'd5, 7'h7F, 32'h1234_5678);
        run_one();
        chk("ntype_instr", INSTR, 32'h0000_000F);
        chk("ntype_rerr",  RANGE_ERR, 1'b0);

        // itype out of range still packs truncated bits
        set_beat(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800);
        run_one();
        chk("iovf_instr", INSTR, 32'h8000_0093);
        chk("iovf_rerr",  RANGE_ERR, 1'b1);

        set_beat(3'd2, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd6);
        run_one();
        chk("b6_instr", INSTR, 32'h0000_0363);
        chk("b6_rerr",  RANGE_ERR, 1'b0);

        set_beat(3'd2, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
        run_one();
        chk("b3_rerr", RANGE_ERR, 1'b1);

        set_beat(3'd4, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
        run_one();
        chk("jodd_rerr", RANGE_ERR, 1'b1);

        set_beat(3'd3, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001);
        run_one();
        chk("ubad_instr", INSTR, 32'h1234_52B7);
        chk("ubad_rerr",  RANGE_ERR, 1'b1);

        set_beat(3'd3, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
        run_one();
        chk("uok_rerr", RANGE_ERR, 1'b0);

        set_beat(3'd7, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0);
        run_one();
        chk("rsvd_instr", INSTR, 32'h0000_0013);
        chk("rsvd_rerr",  RANGE_ERR, 1'b1);

        // Asynchronous reset with a word held at the output
        pulse_reset();
        for (int k = 1; k <= 4; k++) begin
            set_beat(3'd0, 7'h13, 5'(k), 5'd0, 5'd0, 3'd0, 7'd0, 32'(k));
            run_one();
        end
        OUT_READY = 1'b0;
        chk("pre_rst_valid", OUT_VALID, 1'b1);
        chk("pre_rst_count", ENC_COUNT, 16'd3);
        #2;
        RST = 1'b1;
        #1;
        chk("arst_valid",    OUT_VALID, 1'b0);
        chk("arst_instr",    INSTR,     32'h0);
        chk("arst_count",    ENC_COUNT, 16'd0);
        chk("arst_in_ready", IN_READY,  1'b0);
        @(posedge CLK); #1;
        RST = 1'b0;
        OUT_READY = 1'b1;
        chk("rel_valid", OUT_VALID, 1'b0);
        set_beat(3'd0, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7);
        run_one();
        chk("rel_valid2", OUT_VALID, 1'b1);
        chk("rel_instr",  INSTR, 32'h0070_0113);

        // Backpressure: 5 beats, consumer stalls for cycles 3..6
        pulse_reset();
        for (int k = 0; k < 5; k++)
            exp_bp[k] = (32'(k + 1) << 20) | (32'(k + 1) << 7) | 32'h13;
        sent = 0; rcv = 0; have_hold = 1'b0; saw_stall = 1'b0;
        for (int cyc = 0; cyc < 40 && rcv < 5; cyc++) begin
            OUT_READY = !(cyc >= 3 && cyc <= 6);
            if (sent < 5) begin
                set_beat(3'd0, 7'h13, 5'(sent + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'(sent + 1));
                IN_VALID = 1'b1;
            end else begin
                IN_VALID = 1'b0;
            end
            #4;
            if (IN_VALID && !IN_READY) saw_stall = 1'b1;
            if (OUT_VALID) begin
                if (have_hold) chk("bp_hold", INSTR, hold);
                if (OUT_READY) begin
                    chk($sformatf("bp_word%0d", rcv), INSTR, exp_bp[rcv]);
                    rcv++;
                    have_hold = 1'b0;
                end else begin
                    hold = INSTR;
                    have_hold = 1'b1;
                end
            end
            if (IN_VALID && IN_READY) sent++;
            @(posedge CLK); #1;
        end
        IN_VALID = 1'b0;
        OUT_READY = 1'b1;
        chk("bp_in_ready_fell", saw_stall, 1'b1);
        chk("bp_received",      rcv, 5);
        chk("bp_enc_count",     ENC_COUNT, 16'd5);

        // Random round trip over the immediate-carrying formats
        for (int t = 0; t < 5; t++) begin
            for (int n = 0; n < 400; n++) begin
                r = $urandom;
                case (t)
                    0, 1:    rimm = {{20{r[11]}}, r[11:0]};
                    2:       rimm = {{19{r[12]}}, r[12:1], 1'b0};
                    3:       rimm = {r[31:12], 12'b0};
                    default: rimm = {{11{r[20]}}, r[20:1], 1'b0};
                endcase
                rop  = 7'($urandom);
                rrd  = 5'($urandom);
                rrs1 = 5'($urandom);
                rrs2 = 5'($urandom);
                rf3  = 3'($urandom);
                set_beat(3'(t), rop, rrd, rrs1, rrs2, rf3, 7'($urandom), rimm);
                run_one();
                chk("rt_valid", OUT_VALID, 1'b1);
                chk("rt_rerr",  RANGE_ERR, 1'b0);
                chk("rt_imm",   ext_imm(3'(t), INSTR), rimm);
                chk("rt_op",    INSTR[6:0], rop);
                if (t == 0 || t == 3 || t == 4) chk("rt_rd", INSTR[11:7], rrd);
                if (t <= 2) begin
                    chk("rt_rs1", INSTR[19:15], rrs1);
                    chk("rt_f3",  INSTR[14:12], rf3);
                end
                if (t == 1 || t == 2) chk("rt_rs2", INSTR[24:20], rrs2);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
